// File: rtl/ps2_pkg.sv
// Shared constants and types for the PS/2 key-event decoder.
package ps2_pkg;

  localparam logic [7:0] PS2_PREFIX_EXT = 8'hE0;
  localparam logic [7:0] PS2_PREFIX_BRK = 8'hF0;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_EXT     = 2'd1,
    ST_BRK     = 2'd2,
    ST_EXT_BRK = 2'd3
  } ps2_state_e;

  typedef struct packed {
    logic       ext;
    logic       brk;
    logic [7:0] code;
  } ps2_event_t;

endpackage

// File: rtl/ps2_event_fifo.sv
// First-word-fall-through event FIFO; a push while full is accepted only
// alongside a pop, otherwise it is dropped and flagged on drop_o.
module ps2_event_fifo
  import ps2_pkg::*;
#(
  parameter int DEPTH = 8
) (
  input  logic       clk_i,
  input  logic       rst_i,
  input  logic       push_i,
  input  ps2_event_t push_data_i,
  input  logic       pop_i,
  output logic       valid_o,
  output ps2_event_t data_o,
  output logic       drop_o
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH + 1);

  ps2_event_t      mem_q [DEPTH];
  logic [PW-1:0]   wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]   rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]   count_q, count_d;
  logic            full;
  logic            do_push;
  logic            do_pop;

  assign full    = (count_q == CW'(DEPTH));
  assign valid_o = (count_q != '0);
  assign data_o  = mem_q[rd_ptr_q];
  assign do_pop  = pop_i && valid_o;
  assign do_push = push_i && (!full || do_pop);
  assign drop_o  = push_i && full && !do_pop;

  // Pointers wrap naturally because DEPTH is a power of two.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (do_push) wr_ptr_d = wr_ptr_q + 1'b1;
    if (do_pop)  rd_ptr_d = rd_ptr_q + 1'b1;
    case ({do_push, do_pop})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_i && do_push) mem_q[wr_ptr_q] <= push_data_i;
  end

endmodule

// File: rtl/ps2_key_event_decoder.sv
// PS/2 scancode byte stream to key make/break events, with raw-byte history
// and held-key tracking. Optional macro PS2_TYPEMATIC_FILTER_EN drops repeats.
//
//   state      | meaning
//   ST_IDLE    | no prefix pending
//   ST_EXT     | E0 seen
//   ST_BRK     | F0 seen
//   ST_EXT_BRK | both E0 and F0 seen
module ps2_key_event_decoder
  import ps2_pkg::*;
#(
  parameter int FIFO_DEPTH = 8,
  parameter int HIST_BYTES = 4
) (
  input  logic                    CLOCK_50,
  input  logic                    reset,
  input  logic [7:0]              received_data,
  input  logic                    received_data_en,
  output logic                    evt_valid,
  output logic [7:0]              evt_code,
  output logic                    evt_ext,
  output logic                    evt_break,
  input  logic                    evt_ready,
  output logic                    fifo_overflow,
  output logic [7:0]              last_data_received,
  output logic [8*HIST_BYTES-1:0] history,
  output logic                    held_valid,
  output logic                    held_ext,
  output logic [7:0]              held_code
);

  ps2_state_e              state_q, state_d;
  ps2_event_t              ev;
  ps2_event_t              head;
  logic                    emit;
  logic                    push;
  logic                    drop;
  logic                    held_match;
  logic                    ovf_q, ovf_d;
  logic [7:0]              last_q, last_d;
  logic [8*HIST_BYTES-1:0] hist_q, hist_d;
  logic                    held_valid_q, held_valid_d;
  logic                    held_ext_q, held_ext_d;
  logic [7:0]              held_code_q, held_code_d;

  always_comb begin
    state_d = state_q;
    emit    = 1'b0;
    ev      = '0;
    if (received_data_en) begin
      if (received_data == PS2_PREFIX_EXT) begin
        state_d = (state_q == ST_BRK || state_q == ST_EXT_BRK) ? ST_EXT_BRK : ST_EXT;
      end else if (received_data == PS2_PREFIX_BRK) begin
        state_d = (state_q == ST_EXT || state_q == ST_EXT_BRK) ? ST_EXT_BRK : ST_BRK;
      end else begin
        emit    = 1'b1;
        ev.ext  = (state_q == ST_EXT) || (state_q == ST_EXT_BRK);
        ev.brk  = (state_q == ST_BRK) || (state_q == ST_EXT_BRK);
        ev.code = received_data;
        state_d = ST_IDLE;
      end
    end
  end

  assign held_match = held_valid_q && (ev.ext == held_ext_q) && (ev.code == held_code_q);

  always_comb begin
    held_valid_d = held_valid_q;
    held_ext_d   = held_ext_q;
    held_code_d  = held_code_q;
    if (emit && !ev.brk) begin
      held_valid_d = 1'b1;
      held_ext_d   = ev.ext;
      held_code_d  = ev.code;
    end else if (emit && ev.brk && held_match) begin
      held_valid_d = 1'b0;
    end
  end

`ifdef PS2_TYPEMATIC_FILTER_EN
  // Auto-repeat of the held key produces identical makes; suppress them.
  assign push = emit && !(!ev.brk && held_match);
`else
  assign push = emit;
`endif

  generate
    if (HIST_BYTES == 1) begin : g_hist_one
      assign hist_d = received_data_en ? received_data : hist_q;
    end else begin : g_hist_shift
      assign hist_d = received_data_en ? {hist_q[8*HIST_BYTES-9:0], received_data} : hist_q;
    end
  endgenerate

  assign last_d = received_data_en ? received_data : last_q;
  assign ovf_d  = ovf_q | drop;

  always_ff @(posedge CLOCK_50) begin
    if (reset) begin
      state_q      <= ST_IDLE;
      ovf_q        <= 1'b0;
      last_q       <= '0;
      hist_q       <= '0;
      held_valid_q <= 1'b0;
      held_ext_q   <= 1'b0;
      held_code_q  <= '0;
    end else begin
      state_q      <= state_d;
      ovf_q        <= ovf_d;
      last_q       <= last_d;
      hist_q       <= hist_d;
      held_valid_q <= held_valid_d;
      held_ext_q   <= held_ext_d;
      held_code_q  <= held_code_d;
    end
  end

  ps2_event_fifo #(
    .DEPTH(FIFO_DEPTH)
  ) u_fifo (
    .clk_i      (CLOCK_50),
    .rst_i      (reset),
    .push_i     (push),
    .push_data_i(ev),
    .pop_i      (evt_ready),
    .valid_o    (evt_valid),
    .data_o     (head),
    .drop_o     (drop)
  );

  assign evt_code           = head.code;
  assign evt_ext            = head.ext;
  assign evt_break          = head.brk;
  assign fifo_overflow      = ovf_q;
  assign last_data_received = last_q;
  assign history            = hist_q;
  assign held_valid         = held_valid_q;
  assign held_ext           = held_ext_q;
  assign held_code          = held_code_q;

endmodule

// File: tb/tb_ps2_key_event_decoder.sv
// Directed bench for ps2_key_event_decoder; honours PS2_TYPEMATIC_FILTER_EN.
module tb_ps2_key_event_decoder;

  logic        CLOCK_50;
  logic        reset;
  logic [7:0]  received_data;
  logic        received_data_en;
  logic        evt_valid;
  logic [7:0]  evt_code;
  logic        evt_ext;
  logic        evt_break;
  logic        evt_ready;
  logic        fifo_overflow;
  logic [7:0]  last_data_received;
  logic [31:0] history;
  logic        held_valid;
  logic        held_ext;
  logic [7:0]  held_code;

  int errors = 0;
  int checks = 0;
  int n_ev;

  ps2_key_event_decoder #(.FIFO_DEPTH(8), .HIST_BYTES(4)) dut (
    .CLOCK_50          (CLOCK_50),
    .reset             (reset),
    .received_data     (received_data),
    .received_data_en  (received_data_en),
    .evt_valid         (evt_valid),
    .evt_code          (evt_code),
    .evt_ext           (evt_ext),
    .evt_break         (evt_break),
    .evt_ready         (evt_ready),
    .fifo_overflow     (fifo_overflow),
    .last_data_received(last_data_received),
    .history           (history),
    .held_valid        (held_valid),
    .held_ext          (held_ext),
    .held_code         (held_code)
  );

  initial CLOCK_50 = 1'b0;
  always #5 CLOCK_50 = ~CLOCK_50;

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  // Inputs change on the falling edge; outputs are sampled on the next one.
  task automatic send(input logic [7:0] b);
    received_data    = b;
    received_data_en = 1'b1;
    @(negedge CLOCK_50);
    received_data_en = 1'b0;
  endtask

  task automatic pop_chk(input string tag, input logic e, input logic b, input logic [7:0] c);
    chk({tag, "_valid"}, {31'd0, evt_valid}, 32'd1);
    chk(tag, {22'd0, evt_ext, evt_break, evt_code}, {22'd0, e, b, c});
    evt_ready = 1'b1;
    @(negedge CLOCK_50);
    evt_ready = 1'b0;
  endtask

  task automatic drain(output int n);
    n = 0;
    for (int i = 0; i < 20; i++) begin
      if (!evt_valid) break;
      evt_ready = 1'b1;
      @(negedge CLOCK_50);
      evt_ready = 1'b0;
      n++;
    end
  endtask

  task automatic do_reset();
    reset = 1'b1;
    @(negedge CLOCK_50);
    reset = 1'b0;
  endtask

  initial begin
    reset            = 1'b1;
    received_data    = 8'h00;
    received_data_en = 1'b0;
    evt_ready        = 1'b0;
    repeat (2) @(negedge CLOCK_50);
    chk("rst_valid", {31'd0, evt_valid}, 32'd0);
    chk("rst_ovf", {31'd0, fifo_overflow}, 32'd0);
    chk("rst_hist", history, 32'd0);
    reset = 1'b0;

    // Make then break of 1C with the consumer always ready.
    evt_ready = 1'b1;
    send(8'h1C);
    chk("s1_ev0_valid", {31'd0, evt_valid}, 32'd1);
    chk("s1_ev0", {22'd0, evt_ext, evt_break, evt_code}, {22'd0, 1'b0, 1'b0, 8'h1C});
    send(8'hF0);
    chk("s1_prefix_no_ev", {31'd0, evt_valid}, 32'd0);
    send(8'h1C);
    chk("s1_ev1_valid", {31'd0, evt_valid}, 32'd1);
    chk("s1_ev1", {22'd0, evt_ext, evt_break, evt_code}, {22'd0, 1'b0, 1'b1, 8'h1C});
    chk("s1_hist", history, 32'h001C_F01C);
    chk("s1_last", {24'd0, last_data_received}, 32'h1C);
    @(negedge CLOCK_50);
    evt_ready = 1'b0;
    chk("s1_empty", {31'd0, evt_valid}, 32'd0);

    // Extended key press/release.
    send(8'hE0);
    send(8'h75);
    chk("s2_held", {22'd0, held_valid, held_ext, held_code}, {22'd0, 1'b1, 1'b1, 8'h75});
    send(8'hE0);
    send(8'hF0);
    send(8'h75);
    chk("s2_released", {31'd0, held_valid}, 32'd0);
    pop_chk("s2_ev0", 1'b1, 1'b0, 8'h75);
    pop_chk("s2_ev1", 1'b1, 1'b1, 8'h75);
    chk("s2_empty", {31'd0, evt_valid}, 32'd0);

    // Overflow: nine makes into an eight-deep FIFO with no consumer.
    for (int i = 1; i <= 9; i++) send(8'(i));
    chk("s3_ovf", {31'd0, fifo_overflow}, 32'd1);
    for (int i = 1; i <= 8; i++) pop_chk($sformatf("s3_pop%0d", i), 1'b0, 1'b0, 8'(i));
    chk("s3_empty", {31'd0, evt_valid}, 32'd0);

    // Full FIFO with simultaneous push and pop: nothing lost.
    do_reset();
    chk("s4_ovf_clr", {31'd0, fifo_overflow}, 32'd0);
    for (int i = 0; i < 8; i++) send(8'h11 + 8'(i));
    received_data    = 8'h19;
    received_data_en = 1'b1;
    evt_ready        = 1'b1;
    @(negedge CLOCK_50);
    received_data_en = 1'b0;
    evt_ready        = 1'b0;
    chk("s4_no_ovf", {31'd0, fifo_overflow}, 32'd0);
    for (int i = 0; i < 8; i++) pop_chk($sformatf("s4_pop%0d", i), 1'b0, 1'b0, 8'h12 + 8'(i));
    chk("s4_empty", {31'd0, evt_valid}, 32'd0);

    // Typematic repeat.
    do_reset();
    for (int i = 0; i < 5; i++) send(8'h1C);
    send(8'hF0);
    send(8'h1C);
    drain(n_ev);
`ifdef PS2_TYPEMATIC_FILTER_EN
    chk("s5_count", n_ev, 32'd2);
`else
    chk("s5_count", n_ev, 32'd6);
`endif
    chk("s5_held", {31'd0, held_valid}, 32'd0);

    // Reset mid-prefix, colliding with a strobe.
    send(8'h2A);
    send(8'hE0);
    reset            = 1'b1;
    received_data    = 8'hF0;
    received_data_en = 1'b1;
    @(negedge CLOCK_50);
    chk("s6_rst_valid", {31'd0, evt_valid}, 32'd0);
    chk("s6_rst_last", {24'd0, last_data_received}, 32'd0);
    chk("s6_rst_hist", history, 32'd0);
    chk("s6_rst_held", {22'd0, held_valid, held_ext, held_code}, 32'd0);
    chk("s6_rst_ovf", {31'd0, fifo_overflow}, 32'd0);
    reset            = 1'b0;
    received_data_en = 1'b0;
    send(8'h1C);
    pop_chk("s6_ev", 1'b0, 1'b0, 8'h1C);
    chk("s6_empty", {31'd0, evt_valid}, 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
